// File: rtl/rhd_spi_master_if.sv
// Command/response handshake between the acquisition sequencer and the
// RHD2000 SPI master. The sequencer takes the master modport, the SPI block
// takes the slave modport.
interface rhd_spi_master_if;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] rsp_data;
  logic        rsp_valid;
  logic        busy;

  modport master (
    output cmd_data, cmd_valid,
    input  cmd_ready, rsp_data, rsp_valid, busy
  );

  modport slave (
    input  cmd_data, cmd_valid,
    output cmd_ready, rsp_data, rsp_valid, busy
  );
endinterface

// File: rtl/rhd_spi_master.sv
// SPI master for an RHD2000-family headstage (CPOL=0, MSB first, 16-bit frames).
// One command word per frame; the MISO word captured during the frame is
// returned with a one-cycle rsp_valid pulse as CS rises.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | CS high, waiting for a command (cmd_ready=1)
// SETUP    | CS low, first MOSI bit settling before the first SCLK rise
// SHIFT_HI | SCLK high; MISO sampled on entry
// SHIFT_LO | SCLK low; MOSI advanced on entry while bits remain
// GAP      | CS high between frames, response published on entry
module rhd_spi_master #(
  parameter int CLK_DIV        = 2,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  rhd_spi_master_if.slave   bus,
  output logic              CS,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(CS_HIGH_CYCLES - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [7:0]  gap_cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] tx_sr;
  logic [15:0] rx_sr;
  logic [15:0] rsp_data_q;
  logic        rsp_valid_q;
  logic        busy_q;

  // Only cmd_ready is decoded combinationally so a command can be taken in
  // the first IDLE cycle; it is held low while reset is asserted.
  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.busy      = busy_q;

  // Frame sequencer: half-period and gap timers count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      gap_cnt     <= '0;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      CS          <= 1'b1;
      SCLK        <= 1'b0;
      MOSI        <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            tx_sr   <= bus.cmd_data;
            MOSI    <= bus.cmd_data[15];
            CS      <= 1'b0;
            SCLK    <= 1'b0;
            div_cnt <= DIV_LOAD;
            bit_cnt <= '0;
            busy_q  <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == 8'd0) begin
            SCLK    <= 1'b1;
            rx_sr   <= {rx_sr[14:0], MISO};
            bit_cnt <= bit_cnt + 5'd1;
            div_cnt <= DIV_LOAD;
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        SHIFT_HI: begin
          if (div_cnt == 8'd0) begin
            SCLK    <= 1'b0;
            div_cnt <= DIV_LOAD;
            state   <= SHIFT_LO;
            // After the 16th bit MOSI keeps bit 0 until CS rises.
            if (bit_cnt < 5'd16) begin
              MOSI  <= tx_sr[14];
              tx_sr <= {tx_sr[14:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        SHIFT_LO: begin
          if (div_cnt == 8'd0) begin
            if (bit_cnt == 5'd16) begin
              CS          <= 1'b1;
              MOSI        <= 1'b0;
              rsp_data_q  <= rx_sr;
              rsp_valid_q <= 1'b1;
              gap_cnt     <= GAP_LOAD;
              state       <= GAP;
            end else begin
              SCLK    <= 1'b1;
              rx_sr   <= {rx_sr[14:0], MISO};
              bit_cnt <= bit_cnt + 5'd1;
              div_cnt <= DIV_LOAD;
              state   <= SHIFT_HI;
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          CS     <= 1'b1;
          SCLK   <= 1'b0;
          MOSI   <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rhd_spi_master.sv
// Directed bench for rhd_spi_master: default-parameter instance (a) for
// loopback, fixed-MISO, back-to-back and mid-frame reset; fast instance (b)
// with CLK_DIV=1, CS_HIGH_CYCLES=1. Cycle labels: the cycle following rising
// edge n is labelled n+1; T is the label of the cycle in which the command
// handshake is observed.
module tb_rhd_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rhd_spi_master_if ifa ();
  rhd_spi_master_if ifb ();

  logic cs_a, sclk_a, mosi_a, miso_a;
  logic cs_b, sclk_b, mosi_b, miso_b;
  logic loop_a   = 1'b1;
  logic miso_fix = 1'b0;

  assign miso_a = loop_a ? mosi_a : miso_fix;
  assign miso_b = mosi_b;

  rhd_spi_master dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave),
    .CS (cs_a), .SCLK (sclk_a), .MOSI (mosi_a), .MISO (miso_a)
  );

  rhd_spi_master #(.CLK_DIV(1), .CS_HIGH_CYCLES(1)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave),
    .CS (cs_b), .SCLK (sclk_b), .MOSI (mosi_b), .MISO (miso_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
      else begin
        errs++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Bus monitor on instance a.
  logic mon_en    = 1'b0;
  logic abort     = 1'b0;
  logic prev_cs   = 1'b1;
  logic prev_sclk = 1'b0;
  logic prev_mosi = 1'b0;
  int   rise_cnt  = 0;
  int   first_rise = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_sclk && sclk_a) chk("mosi_stable_sclk_high", mosi_a, prev_mosi);
      if (cs_a) chk("sclk_low_cs_high", sclk_a, 1'b0);
      if (!cs_a && sclk_a && !prev_sclk) begin
        if (rise_cnt == 0) first_rise = cyc + 1;
        rise_cnt++;
      end
      if (cs_a && !prev_cs) begin
        if (!abort) chk("sclk_rises_per_frame", rise_cnt, 16);
        rise_cnt = 0;
      end
    end
    prev_cs   = cs_a;
    prev_sclk = sclk_a;
    prev_mosi = mosi_a;
  end

  // Call at a negedge. Returns at the negedge after the accepting edge.
  task automatic send_a(input logic [15:0] cmd, input bit keep, output int t);
    bit ok = 0;
    t = 0;
    ifa.cmd_data  = cmd;
    ifa.cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (ifa.cmd_ready) begin t = cyc + 1; ok = 1; break; end
      @(negedge clk);
    end
    chk("accept_timeout", ok, 1'b1);
    @(negedge clk);
    if (!keep) ifa.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_a(output int t, output logic [15:0] d,
                            output logic m_or, output logic m_and);
    bit ok = 0;
    t = 0; d = '0; m_or = 1'b0; m_and = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (ifa.rsp_valid) begin t = cyc + 1; d = ifa.rsp_data; ok = 1; break; end
      if (!cs_a) begin m_or = m_or | mosi_a; m_and = m_and & mosi_a; end
      @(negedge clk);
    end
    chk("rsp_timeout", ok, 1'b1);
  endtask

  task automatic wait_ready_a(output int t);
    bit ok = 0;
    t = 0;
    for (int i = 0; i < 300; i++) begin
      if (ifa.cmd_ready) begin t = cyc + 1; ok = 1; break; end
      @(negedge clk);
    end
    chk("ready_timeout", ok, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2, t3, tr, tq;
    logic [15:0] d;
    logic m_or, m_and;
    int cs_low, rises, first_b, last_b, trsp_b;
    logic pv;
    bit ok;

    ifa.cmd_data = '0; ifa.cmd_valid = 1'b0;
    ifb.cmd_data = '0; ifb.cmd_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs", cs_a, 1'b1);
    chk("rst_sclk", sclk_a, 1'b0);
    chk("rst_mosi", mosi_a, 1'b0);
    chk("rst_rsp_valid", ifa.rsp_valid, 1'b0);
    chk("rst_rsp_data", ifa.rsp_data, 16'h0000);
    chk("rst_busy", ifa.busy, 1'b0);
    chk("rst_ready_gated", ifa.cmd_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", ifa.cmd_ready, 1'b1);
    mon_en = 1'b1;

    // Loopback 0xA5C3 with cmd_data scrambled after acceptance
    send_a(16'hA5C3, 0, t);
    ifa.cmd_data = 16'hDEAD;
    chk("lb_cs_low_T1", cs_a, 1'b0);
    chk("lb_busy_T1", ifa.busy, 1'b1);
    chk("lb_mosi_msb_T1", mosi_a, 1'b1);
    chk("lb_ready_low_T1", ifa.cmd_ready, 1'b0);
    wait_rsp_a(tr, d, m_or, m_and);
    chk("lb_first_rise", first_rise - t, 3);
    chk("lb_rsp_time", tr - t, 67);
    chk("lb_rsp_data", d, 16'hA5C3);
    chk("lb_cs_high_at_rsp", cs_a, 1'b1);
    @(negedge clk);
    chk("lb_rsp_one_cycle", ifa.rsp_valid, 1'b0);
    chk("lb_busy_in_gap", ifa.busy, 1'b1);
    wait_ready_a(tq);
    chk("lb_ready_time", tq - t, 71);
    chk("lb_busy_idle", ifa.busy, 1'b0);

    // Fixed MISO=1, all-zero command
    loop_a = 1'b0; miso_fix = 1'b1;
    send_a(16'h0000, 0, t);
    wait_rsp_a(tr, d, m_or, m_and);
    chk("fix1_mosi_never_high", m_or, 1'b0);
    chk("fix1_rsp_data", d, 16'hFFFF);
    wait_ready_a(tq);

    // Fixed MISO=0, all-ones command
    miso_fix = 1'b0;
    send_a(16'hFFFF, 0, t);
    wait_rsp_a(tr, d, m_or, m_and);
    chk("fix0_mosi_always_high", m_and, 1'b1);
    chk("fix0_rsp_data", d, 16'h0000);
    wait_ready_a(tq);

    // Back-to-back with cmd_valid held high
    loop_a = 1'b1;
    send_a(16'h1234, 1, t1);
    wait_rsp_a(tr, d, m_or, m_and);
    chk("b2b_rsp0", d, 16'h1234);
    send_a(16'h8001, 1, t2);
    chk("b2b_period0", t2 - t1, 71);
    wait_rsp_a(tr, d, m_or, m_and);
    chk("b2b_rsp1", d, 16'h8001);
    send_a(16'h7FFE, 0, t3);
    chk("b2b_period1", t3 - t2, 71);
    wait_rsp_a(tr, d, m_or, m_and);
    chk("b2b_rsp2", d, 16'h7FFE);
    wait_ready_a(tq);

    // Fast instance: CLK_DIV=1, CS_HIGH_CYCLES=1, loopback 0xC0DE
    ifb.cmd_data = 16'hC0DE; ifb.cmd_valid = 1'b1;
    ok = 0; t = 0;
    for (int i = 0; i < 50; i++) begin
      if (ifb.cmd_ready) begin t = cyc + 1; ok = 1; break; end
      @(negedge clk);
    end
    chk("b_accept_timeout", ok, 1'b1);
    @(negedge clk);
    ifb.cmd_valid = 1'b0;
    cs_low = 0; rises = 0; first_b = 0; last_b = 0; trsp_b = 0; pv = 1'b0; ok = 0; d = '0;
    for (int i = 0; i < 100; i++) begin
      if (ifb.rsp_valid) begin trsp_b = cyc + 1; d = ifb.rsp_data; ok = 1; break; end
      if (!cs_b) cs_low++;
      if (!cs_b && sclk_b && !pv) begin
        if (rises == 0) first_b = cyc + 1;
        last_b = cyc + 1;
        rises++;
      end
      pv = sclk_b;
      @(negedge clk);
    end
    chk("b_rsp_timeout", ok, 1'b1);
    chk("b_cs_low_cycles", cs_low, 33);
    chk("b_sclk_rises", rises, 16);
    chk("b_first_rise", first_b - t, 2);
    chk("b_last_rise", last_b - t, 32);
    chk("b_rsp_time", trsp_b - t, 34);
    chk("b_rsp_data", d, 16'hC0DE);
    @(negedge clk);
    chk("b_ready_time", ifb.cmd_ready ? (cyc + 1 - t) : 0, 35);

    // Reset in the middle of a frame
    send_a(16'hFFFF, 0, t);
    while (cyc + 1 < t + 20) @(negedge clk);
    abort = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_cs", cs_a, 1'b1);
    chk("mrst_sclk", sclk_a, 1'b0);
    chk("mrst_mosi", mosi_a, 1'b0);
    chk("mrst_busy", ifa.busy, 1'b0);
    chk("mrst_rsp_valid", ifa.rsp_valid, 1'b0);
    chk("mrst_rsp_cleared", ifa.rsp_data, 16'h0000);
    rst = 1'b0;
    m_or = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      m_or = m_or | ifa.rsp_valid | ~cs_a;
    end
    chk("mrst_no_late_activity", m_or, 1'b0);
    abort = 1'b0;
    send_a(16'h00FF, 0, t);
    wait_rsp_a(tr, d, m_or, m_and);
    chk("post_rst_rsp_time", tr - t, 67);
    chk("post_rst_rsp_data", d, 16'h00FF);
    wait_ready_a(tq);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
